// File: rtl/mm_pkg.sv
// Shared types and sizes for the 8x8 multiplier datapath: row/set/product
// types and the row-weighting helper used by the partial-product reducer.
package mm_pkg;

  localparam int W     = 8;
  localparam int PW    = 2 * W;
  localparam int TAG_W = 4;

  typedef logic [W-1:0]  pp_row_t;
  typedef pp_row_t       pp_set_t [W];
  typedef logic [PW-1:0] prod_t;

  // Row idx of the partial-product array carries weight 2^idx.
  function automatic prod_t weight_row(input pp_row_t row, input int unsigned idx);
    return prod_t'(row) << idx;
  endfunction

endpackage

// File: rtl/pp_reduce_pipe_if.sv
// Valid/ready bundle between the partial-product generator, the reducer
// and the dot-product stage; slave is the reducer's view.
interface pp_reduce_pipe_if;
  import mm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  pp_set_t          P;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  prod_t            product;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, P, in_tag, out_ready,
    output in_ready, out_valid, product, out_tag
  );

  modport master (
    output in_valid, P, in_tag, out_ready,
    input  in_ready, out_valid, product, out_tag
  );

endinterface

// File: rtl/pp_add_stage.sv
// One level of the reduction tree: N_IN terms in, N_IN/2 registered pairwise
// sums out, with a valid bit and tag that move only when adv is high.
module pp_add_stage #(
  parameter int N_IN  = 8,
  parameter int PW    = 16,
  parameter int TAG_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      adv,
  input  logic                      in_valid,
  input  logic [N_IN*PW-1:0]        in_terms,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  output logic [(N_IN/2)*PW-1:0]    out_terms,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int N_OUT = N_IN / 2;

  logic                   valid_d, valid_q;
  logic [N_OUT*PW-1:0]    sum_d, sum_q;
  logic [TAG_W-1:0]       tag_d, tag_q;

  // Bubbles load like data so the whole pipe moves in lock step.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    tag_d   = tag_q;
    if (adv) begin
      valid_d = in_valid;
      tag_d   = in_tag;
      for (int j = 0; j < N_OUT; j++) begin
        sum_d[j*PW +: PW] = in_terms[(2*j)*PW +: PW] + in_terms[(2*j+1)*PW +: PW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_terms = sum_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/pp_reduce_pipe.sv
// Pipelined partial-product reducer: weights each row by 2^i and sums them
// through a log2(W)-level registered adder tree under one global stall.
module pp_reduce_pipe
  import mm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  pp_reduce_pipe_if.slave  bus
);

  localparam int L       = $clog2(W);
  localparam int N_TERMS = 2 * W - 1;

  logic                       adv;
  logic [N_TERMS*PW-1:0]      tree;
  logic [L:0]                 vld;
  logic [L:0][TAG_W-1:0]      tag;

  assign adv          = !vld[L] || bus.out_ready;
  assign bus.in_ready = adv;
  assign vld[0]       = bus.in_valid && adv;
  assign tag[0]       = bus.in_tag;

  for (genvar i = 0; i < W; i++) begin : g_weight
    assign tree[i*PW +: PW] = weight_row(bus.P[i], i);
  end

  // Every level's terms live back to back in tree: level k starts at term 2W - 2*(W>>k).
  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int N_IN    = W >> k;
    localparam int OFF_IN  = 2 * W - 2 * N_IN;
    localparam int OFF_OUT = OFF_IN + N_IN;

    pp_add_stage #(
      .N_IN  (N_IN),
      .PW    (PW),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .in_valid  (vld[k]),
      .in_terms  (tree[OFF_IN*PW +: N_IN*PW]),
      .in_tag    (tag[k]),
      .out_valid (vld[k+1]),
      .out_terms (tree[OFF_OUT*PW +: (N_IN/2)*PW]),
      .out_tag   (tag[k+1])
    );
  end

  assign bus.out_valid = vld[L];
  assign bus.product   = tree[(N_TERMS-1)*PW +: PW];
  assign bus.out_tag   = tag[L];

endmodule

// File: tb/tb_pp_reduce_pipe.sv
// Bench for pp_reduce_pipe: directed vectors, stream, stall and random traffic
// checked against an A*B reference through an in-order scoreboard.
module tb_pp_reduce_pipe;
  import mm_pkg::*;

  typedef enum {RDY_ON, RDY_OFF, RDY_RAND} ready_mode_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  tag;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] prod;
    logic [3:0]  tag;
    time         accept_time;
  } sb_entry_t;

  logic        clk;
  logic        rst_n;
  ready_mode_t ready_mode;
  sb_entry_t   sb [$];
  sb_entry_t   entry;
  int          checks;
  int          errors;
  bit          check_latency;
  bit          check_gap;
  bit          have_last;
  time         last_retire_t;
  bit          hold_prev;
  logic [15:0] hold_prod;
  logic [3:0]  hold_tag;
  vec_t        vecs [7];

  pp_reduce_pipe_if bus ();

  pp_reduce_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one row set at posedge+1 and hold it until it transfers.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] t, input logic [15:0] exp);
    int wait_cnt;
    bit accepted;
    wait_cnt = 0;
    accepted = 0;
    for (int i = 0; i < W; i++) bus.P[i] = a[i] ? b : 8'h00;
    bus.in_tag   = t;
    bus.in_valid = 1'b1;
    while (!accepted && wait_cnt < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1;
        sb.push_back('{prod: exp, tag: t, accept_time: $time});
      end
      wait_cnt++;
    end
    if (!accepted) checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        RDY_ON:  bus.out_ready = 1'b1;
        RDY_OFF: bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops on retiring transfers, plus held-output stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("hold_product", 32'(bus.product), 32'(hold_prod));
        checkOutput("hold_tag", 32'(bus.out_tag), 32'(hold_tag));
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_prod = bus.product;
      hold_tag  = bus.out_tag;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          entry = sb.pop_front();
          checkOutput("product", 32'(bus.product), 32'(entry.prod));
          checkOutput("tag", 32'(bus.out_tag), 32'(entry.tag));
          if (check_latency)
            checkOutput("latency", 32'(($time - entry.accept_time) / 10), 32'd3);
          if (check_gap && have_last)
            checkOutput("stream_gap", 32'(($time - last_retire_t) / 10), 32'd1);
          last_retire_t = $time;
          have_last     = 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] m;

    checks        = 0;
    errors        = 0;
    check_latency = 0;
    check_gap     = 0;
    have_last     = 0;
    hold_prev     = 0;
    ready_mode    = RDY_ON;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    for (int i = 0; i < W; i++) bus.P[i] = '0;

    vecs[0] = '{8'h01, 8'hFF, 4'd1, 16'h00FF};
    vecs[1] = '{8'hFF, 8'hFF, 4'd2, 16'hFE01};
    vecs[2] = '{8'hFF, 8'h01, 4'd3, 16'h00FF};
    vecs[3] = '{8'hAA, 8'h55, 4'd4, 16'h3872};
    vecs[4] = '{8'h00, 8'h00, 4'd5, 16'h0000};
    vecs[5] = '{8'h80, 8'h80, 4'd6, 16'h4000};
    vecs[6] = '{8'h0F, 8'hF0, 4'd7, 16'h0E10};

    repeat (2) @(posedge clk);
    #5;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_product", 32'(bus.product), 32'd0);
    checkOutput("reset_out_tag", 32'(bus.out_tag), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single set latency");
    check_latency = 1;
    applyStimulus(8'h01, 8'hFF, 4'd1, 16'h00FF);
    waitDrain();
    check_latency = 0;

    $display("[TB] vector table");
    for (int v = 0; v < 7; v++) applyStimulus(vecs[v].a, vecs[v].b, vecs[v].tag, vecs[v].exp);
    waitDrain();

    $display("[TB] back-to-back stream");
    have_last = 0;
    check_gap = 1;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       begin a = 8'h00; b = 8'h00; end
        1:       begin a = 8'h01; b = 8'h01; end
        2:       begin a = 8'hAA; b = 8'h55; end
        default: begin a = 8'(i * 29 + 3); b = 8'(255 - i * 11); end
      endcase
      m = {8'h00, a} * {8'h00, b};
      applyStimulus(a, b, 4'(i), m);
    end
    waitDrain();
    check_gap = 0;

    $display("[TB] stall with full pipe");
    ready_mode = RDY_OFF;
    @(posedge clk);
    #1;
    applyStimulus(8'h11, 8'h22, 4'd11, 16'h0242);
    applyStimulus(8'h33, 8'h44, 4'd12, 16'h0D8C);
    applyStimulus(8'h55, 8'h66, 4'd13, 16'h21DE);
    fork
      applyStimulus(8'h77, 8'h88, 4'd14, 16'h3F38);
      begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        ready_mode = RDY_ON;
      end
    join
    waitDrain();

    $display("[TB] reset mid-stream");
    applyStimulus(8'h12, 8'h34, 4'd9, 16'h03A8);
    applyStimulus(8'h56, 8'h78, 4'd10, 16'h2850);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset_product", 32'(bus.product), 32'd0);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midreset_out_tag", 32'(bus.out_tag), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("flushed_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    ready_mode = RDY_RAND;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      a = 8'($urandom);
      b = 8'($urandom);
      m = {8'h00, a} * {8'h00, b};
      applyStimulus(a, b, 4'(i), m);
    end
    ready_mode = RDY_ON;
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
